// File: rtl/fb_cpu_pkg.sv
// Shared definitions for the FB-CPU core: opcodes, FSM states, default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fb_cpu_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 10;
    localparam int OP_W       = 4;

    localparam logic [OP_W-1:0] OP_LOD = 4'd0;
    localparam logic [OP_W-1:0] OP_STO = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd3;
    localparam logic [OP_W-1:0] OP_MUL = 4'd4;
    localparam logic [OP_W-1:0] OP_JMP = 4'd6;
    localparam logic [OP_W-1:0] OP_JMZ = 4'd7;
    localparam logic [OP_W-1:0] OP_HLT = 4'd9;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        LATCH    = 3'd1,
        DISPATCH = 3'd2,
        EXEC     = 3'd3,
        HALT     = 3'd4
    } state_t;

endpackage

// File: rtl/fb_alu.sv
// Accumulator ALU: computes the next ACC for LOD/ADD/SUB/MUL from ACC and operand.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to capture the result.
module fb_alu
    import fb_cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] acc_nxt
);

    // Results are sized to DATA_W, so all arithmetic wraps modulo 2^DATA_W;
    // a DATA_W-wide multiply is exactly the low half of the full product.
    always_comb begin
        acc_nxt = acc;
        case (op)
            OP_LOD:  acc_nxt = operand;
            OP_ADD:  acc_nxt = acc + operand;
            OP_SUB:  acc_nxt = acc - operand;
            OP_MUL:  acc_nxt = acc * operand;
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/fb_cpu_ctrl.sv
// FB-CPU core: fetch/latch/dispatch/exec sequencer driving a 1-cycle-latency single-port RAM.
// Latency: 4 cycles for LOD/ADD/SUB/MUL, 3 cycles for STO/JMP/JMZ/NOP/HLT.
// Backpressure: none; the RAM is assumed always ready, outputs depend only on registered state.
module fb_cpu_ctrl
    import fb_cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_halt,
    output logic [DATA_W-1:0] o_acc,
    output logic [ADDR_W-1:0] o_pc
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] alu_out;

    logic [OP_W-1:0]   ir_op;
    logic [ADDR_W-1:0] ir_addr;

    assign ir_op   = ir[DATA_W-1 -: OP_W];
    assign ir_addr = ir[ADDR_W-1:0];

    fb_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op      (ir_op),
        .acc     (acc),
        .operand (i_mem_rdata),
        .acc_nxt (alu_out)
    );

    // State register; async reset returns to FETCH so a pending STO write drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    // Next-state decode; undefined opcodes fall back to FETCH as NOPs.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:    state_nxt = LATCH;
            LATCH:    state_nxt = DISPATCH;
            DISPATCH: begin
                case (ir_op)
                    OP_LOD, OP_ADD, OP_SUB, OP_MUL: state_nxt = EXEC;
                    OP_HLT:                         state_nxt = HALT;
                    default:                        state_nxt = FETCH;
                endcase
            end
            EXEC:     state_nxt = FETCH;
            HALT:     state_nxt = HALT;
            default:  state_nxt = FETCH;
        endcase
    end

    // Architectural registers: IR/PC advance in LATCH, jumps resolve in DISPATCH, ACC updates in EXEC.
    // JMZ looks at ACC as of DISPATCH, which already includes any preceding EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= RESET_PC;
            acc <= '0;
            ir  <= '0;
        end else begin
            case (state)
                LATCH: begin
                    ir <= i_mem_rdata;
                    pc <= pc + ADDR_W'(1);
                end
                DISPATCH: begin
                    if ((ir_op == OP_JMP) || ((ir_op == OP_JMZ) && (acc == '0)))
                        pc <= ir_addr;
                end
                EXEC:    acc <= alu_out;
                default: ;
            endcase
        end
    end

    // Memory-side and debug outputs, decoded from registered state only.
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = pc;
        o_mem_wdata = acc;
        o_halt      = 1'b0;
        case (state)
            DISPATCH: begin
                o_mem_addr = ir_addr;
                o_mem_we   = (ir_op == OP_STO);
            end
            EXEC:    o_mem_addr = ir_addr;
            HALT:    o_halt     = 1'b1;
            default: ;
        endcase
    end

    assign o_acc = acc;
    assign o_pc  = pc;

endmodule
